spi_master_sched: RTL and testbench
===================================

# spi_master_sched

Single-clock SPI master and two-port request scheduler that drives the team's SPI slave block over SCK/SS/MOSI/MISO. Two on-chip requesters each submit 8-bit transfers. A round-robin arbiter grants the bus to one requester at a time. The sequencer generates a mode-0 frame of 8 SCK pulses, then returns the received byte and a completion pulse to the granted requester.

## Interface
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.
- SS_GAP, 2: minimum clk cycles SS stays high between frames; legal range 1..255.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  2  transfer request per requester; level, held until matching done.
- tx_data0  in  8  byte to send for requester 0; captured at grant.
- tx_data1  in  8  byte to send for requester 1; captured at grant.
- gnt  out  2  one-hot grant; high for the whole frame.
- done  out  2  one-cycle completion pulse to the granted requester.
- rx_data  out  8  byte received on MISO; valid from the done cycle until the next done.
- busy  out  1  high from grant until the end of the SS gap.
- SCK  out  1  SPI clock; idles low.
- SS  out  1  slave select, active-low; idles high.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave; only sampled while SS is low.

## Operation
- Reset values:
  - SCK=0, SS=1, MOSI=0.
  - gnt=00, done=00, busy=0, rx_data=00.
  - State=IDLE, bit counter=0, divider=0.
  - Round-robin pointer favours requester 0.
- Reset mid-frame aborts immediately. SS rises and SCK drops on the reset edge. No done pulse is issued and rx_data is cleared.
- Arbitration (IDLE only):
  - Only one requester active: grant it.
  - Both active: grant the requester not served last.
  - After each grant, the pointer flips to favour the other requester.
  - The grant registers the selected tx byte into the shift register.
- States: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
  - IDLE -> SETUP when any req is high. Same edge: gnt set, busy=1, SS=0, MOSI=tx[7].
  - SETUP: hold for CLK_DIV cycles, then go to SCK_HI.
  - Entering SCK_HI: SCK=1, MISO sampled into rx shift register LSB (shift left).
  - SCK_HI: hold for CLK_DIV cycles, then go to SCK_LO.
  - Entering SCK_LO: SCK=0, counter+1. If counter<8, MOSI = next tx bit (MSB first).
  - SCK_LO: hold for CLK_DIV cycles. Then go to SCK_HI if counter<8, else exit the frame.
  - Frame exit, same edge: SS=1, MOSI=0, gnt=00, done[granted]=1, rx_data updated, state -> GAP.
  - GAP: hold for SS_GAP cycles with SS=1, then busy=0 and state -> IDLE.
- Mode 0 is required by the slave:
  - The slave loads its TX byte on the SS fall.
  - It samples MOSI on the SCK rise and shifts on the SCK fall.
  - Its OUT register updates on the SS rise.
  - The 8th SCK fall must therefore precede the SS rise by CLK_DIV cycles.
- Dropping req mid-frame is ignored; the frame completes and done still pulses.
- tx_data changes after grant have no effect on the current frame.
- A req still high in the IDLE cycle after done starts a new frame.

## Timing
- Let D = CLK_DIV and G = SS_GAP.
- Req high at edge N (in IDLE): gnt and SS=0 visible after edge N.
- First SCK rise: D cycles after SS falls.
- SCK period: 2D cycles, 50% duty cycle, exactly 8 pulses per frame.
- SS low for exactly 17D cycles. done pulses in the first cycle with SS high.
- Back-to-back frames: SS high for G+1 cycles minimum (G gap cycles plus 1 arbitration cycle).
- Frame-to-frame period: 17D + G + 1 cycles.
- MISO is sampled at the clk edge that raises SCK. The slave changed MISO at the previous SCK fall, so it has had ≥D cycles to settle.
- done is never high for both requesters; gnt is always one-hot or zero.

## Test plan
- Single transfer, D=2, G=2:
  - Stimulus: req0 with tx_data0=A5; slave DATA=3C.
  - MOSI bits 1,0,1,0,0,1,0,1. rx_data=3C when done0 pulses. Slave OUT=A5.
  - SS low 34 cycles; exactly 8 SCK rises.
- Simultaneous req=11 after reset:
  - Grant order 0, 1, 0, 1 while both stay asserted.
  - Each frame separated by 3 SS-high cycles.
  - done0 and done1 alternate, never overlapping.
- req0 dropped after grant and tx_data0 changed mid-frame:
  - The frame finishes with the original byte.
  - done0 pulses once; no second frame starts.
- Reset asserted during the 5th SCK high phase:
  - On the next edge: SS=1, SCK=0, gnt=00, rx_data=00, no done.
  - Next req0 is served normally with the correct byte.
- CLK_DIV=1, SS_GAP=1, tx_data1=FF, slave DATA=00:
  - SCK toggles every cycle; SS low 17 cycles.
  - rx_data=00; slave OUT=FF.

Source files
------------

// File: rtl/spi_master_sched.sv
// rtl/spi_master_sched.sv - two-requester round-robin SPI mode-0 master
module spi_master_sched #(
   parameter int CLK_DIV = 2,
   parameter int SS_GAP  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] tx_data0,
   input  logic [7:0] tx_data1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       SCK,
   output logic       SS,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);

   state_t     state, state_nxt;
   logic [7:0] div_cnt;
   logic [3:0] bit_cnt;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic       sel_q;      // requester owning the current frame
   logic       rr_ptr;     // requester favoured when both ask
   logic       hold_end;
   logic       grant_sel;
   logic       in_frame;

   assign hold_end  = (state == GAP) ? (div_cnt == GAP_LAST) : (div_cnt == DIV_LAST);
   assign grant_sel = (req == 2'b11) ? rr_ptr : req[1];

   // State register; reset drops straight back to IDLE, aborting any frame
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: each timed phase advances when its hold counter expires
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (|req) state_nxt = SETUP;
         SETUP:  if (hold_end) state_nxt = SCK_HI;
         SCK_HI: if (hold_end) state_nxt = SCK_LO;
         SCK_LO: if (hold_end) state_nxt = (bit_cnt < 4'd8) ? SCK_HI : GAP;
         GAP:    if (hold_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: phase timer, arbitration, shift registers and completion
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= 8'd0;
         bit_cnt <= 4'd0;
         tx_sh   <= 8'd0;
         rx_sh   <= 8'd0;
         sel_q   <= 1'b0;
         rr_ptr  <= 1'b0;
         done    <= 2'b00;
         rx_data <= 8'd0;
      end else begin
         done <= 2'b00;
         if (state_nxt != state || state == IDLE) div_cnt <= 8'd0;
         else                                      div_cnt <= div_cnt + 8'd1;
         if (state == IDLE && state_nxt == SETUP) begin
            sel_q   <= grant_sel;
            rr_ptr  <= ~grant_sel;
            tx_sh   <= grant_sel ? tx_data1 : tx_data0;
            bit_cnt <= 4'd0;
            rx_sh   <= 8'd0;
         end
         // MISO is captured on the same edge that raises SCK
         if (state != SCK_HI && state_nxt == SCK_HI) rx_sh <= {rx_sh[6:0], MISO};
         // Falling SCK: count the bit and present the next MOSI bit
         if (state == SCK_HI && state_nxt == SCK_LO) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd7) tx_sh <= {tx_sh[6:0], 1'b0};
         end
         if (state == SCK_LO && state_nxt == GAP) begin
            rx_data <= rx_sh;
            done    <= sel_q ? 2'b10 : 2'b01;
            bit_cnt <= 4'd0;
         end
      end
   end

   // Output decode: SPI pins and grant follow the frame states
   always_comb begin
      in_frame = (state == SETUP) || (state == SCK_HI) || (state == SCK_LO);
      SCK      = (state == SCK_HI);
      SS       = ~in_frame;
      MOSI     = in_frame & tx_sh[7];
      gnt      = in_frame ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
      busy     = (state != IDLE);
   end

endmodule

// File: tb/tb_spi_master_sched.sv
// tb/tb_spi_master_sched.sv - directed and random checks with mode-0 slave model
module tb_spi_master_sched;

   logic       clk;
   logic       rst;
   logic [1:0] req_a  [2];
   logic [7:0] tx0_a  [2];
   logic [7:0] tx1_a  [2];
   logic [1:0] gnt_a  [2];
   logic [1:0] done_a [2];
   logic [7:0] rx_a   [2];
   logic       busy_a [2];
   logic       sck_a  [2];
   logic       ss_a   [2];
   logic       mosi_a [2];
   logic       miso_a [2];

   logic [7:0] s_data [2];
   logic [7:0] s_tx   [2];
   logic [7:0] s_rx   [2];
   logic [7:0] s_out  [2];
   bit         favour [2];

   int n_assert = 0;
   int n_fail   = 0;

   spi_master_sched #(.CLK_DIV(2), .SS_GAP(2)) u_dut0 (
      .clk(clk), .rst(rst), .req(req_a[0]), .tx_data0(tx0_a[0]), .tx_data1(tx1_a[0]),
      .gnt(gnt_a[0]), .done(done_a[0]), .rx_data(rx_a[0]), .busy(busy_a[0]),
      .SCK(sck_a[0]), .SS(ss_a[0]), .MOSI(mosi_a[0]), .MISO(miso_a[0]));

   spi_master_sched #(.CLK_DIV(1), .SS_GAP(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req_a[1]), .tx_data0(tx0_a[1]), .tx_data1(tx1_a[1]),
      .gnt(gnt_a[1]), .done(done_a[1]), .rx_data(rx_a[1]), .busy(busy_a[1]),
      .SCK(sck_a[1]), .SS(ss_a[1]), .MOSI(mosi_a[1]), .MISO(miso_a[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_slave
      always @(negedge ss_a[k]) begin s_tx[k] = s_data[k]; s_rx[k] = 8'h00; end
      always @(posedge sck_a[k]) if (ss_a[k] === 1'b0) s_rx[k] = {s_rx[k][6:0], mosi_a[k]};
      always @(negedge sck_a[k]) if (ss_a[k] === 1'b0) s_tx[k] = {s_tx[k][6:0], 1'b0};
      always @(posedge ss_a[k]) s_out[k] = s_rx[k];
      assign miso_a[k] = (ss_a[k] === 1'b0) ? s_tx[k][7] : 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin reference: sole requester wins, otherwise the favoured one
   function automatic bit pick(input int k, input logic [1:0] r);
      bit w;
      w = (r == 2'b11) ? favour[k] : r[1];
      favour[k] = !w;
      return w;
   endfunction

   task automatic do_frame(input int k, input int d, input int g, input logic [1:0] eg,
                           input logic [7:0] tx, input logic [7:0] sd, input int act_at,
                           input bit drop, input string tag);
      int n, lo, rises, hi, bad_gnt, bad_done, bad_busy;
      logic [7:0] mbits;
      logic psck;
      n = 0; lo = 0; rises = 0; hi = 0; bad_gnt = 0; bad_done = 0; bad_busy = 0;
      mbits = 8'h00; psck = 1'b0;
      while (ss_a[k] !== 1'b0 && n < 6) begin @(negedge clk); n++; end
      check({tag, "_ss_fall"}, ss_a[k], 1'b0);
      check({tag, "_gnt"}, gnt_a[k], eg);
      while (ss_a[k] === 1'b0 && lo < 20 * d + 4) begin
         if (sck_a[k] === 1'b1 && psck === 1'b0) begin
            rises++;
            mbits = {mbits[6:0], mosi_a[k]};
         end
         if (sck_a[k] === 1'b1) hi++;
         if (gnt_a[k] !== eg) bad_gnt++;
         if (done_a[k] !== 2'b00) bad_done++;
         if (busy_a[k] !== 1'b1) bad_busy++;
         psck = sck_a[k];
         lo++;
         if (lo == act_at) begin req_a[k] = 2'b00; tx0_a[k] = ~tx; end
         @(negedge clk);
      end
      check({tag, "_ss_low"}, lo, 17 * d);
      check({tag, "_sck_rises"}, rises, 8);
      check({tag, "_sck_high"}, hi, 8 * d);
      check({tag, "_mosi"}, mbits, tx);
      check({tag, "_gnt_hold"}, bad_gnt, 0);
      check({tag, "_done_early"}, bad_done, 0);
      check({tag, "_done"}, done_a[k], eg);
      check({tag, "_rx"}, rx_a[k], sd);
      check({tag, "_slave_out"}, s_out[k], tx);
      check({tag, "_idle_pins"}, {gnt_a[k], sck_a[k], mosi_a[k]}, 4'b0000);
      if (drop) req_a[k] = 2'b00;
      for (int i = 1; i <= g; i++) begin
         if (busy_a[k] !== 1'b1) bad_busy++;
         if (ss_a[k] !== 1'b1) bad_gnt++;
         if (i > 1 && done_a[k] !== 2'b00) bad_done++;
         @(negedge clk);
      end
      check({tag, "_busy"}, bad_busy, 0);
      check({tag, "_gap"}, {bad_gnt, bad_done}, 64'd0);
      check({tag, "_arb_cycle"}, {busy_a[k], ss_a[k], done_a[k]}, 4'b0100);
   endtask

   initial begin
      int  rises, n;
      logic psck;
      bit  w;
      logic [1:0] r;
      logic [7:0] t0, t1, sd;
      rst = 1'b1;
      favour[0] = 1'b0; favour[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_a[k] = 2'b00; tx0_a[k] = 8'h00; tx1_a[k] = 8'h00; s_data[k] = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_pins%0d", k), {sck_a[k], ss_a[k], mosi_a[k]}, 3'b010);
         check($sformatf("reset_ctl%0d", k), {gnt_a[k], done_a[k], busy_a[k]}, 5'b0);
         check($sformatf("reset_rx%0d", k), rx_a[k], 8'h00);
      end
      rst = 1'b0;
      @(negedge clk);

      // Both requesters held: alternate grants with minimum SS-high gaps
      tx0_a[0] = 8'h3C; tx1_a[0] = 8'hC6; s_data[0] = 8'h5A; req_a[0] = 2'b11;
      for (int i = 0; i < 4; i++) begin
         w = pick(0, 2'b11);
         do_frame(0, 2, 2, w ? 2'b10 : 2'b01, w ? 8'hC6 : 8'h3C, 8'h5A, -1, i == 3,
                  $sformatf("rr%0d", i));
         if (i < 3) begin
            @(negedge clk);
            check($sformatf("rr%0d_b2b", i), ss_a[0], 1'b0);
         end
      end

      // Single transfer
      tx0_a[0] = 8'hA5; s_data[0] = 8'h3C; req_a[0] = 2'b01;
      w = pick(0, 2'b01);
      do_frame(0, 2, 2, 2'b01, 8'hA5, 8'h3C, -1, 1'b1, "single");

      // Request dropped and tx byte changed mid-frame
      tx0_a[0] = 8'h5A; s_data[0] = 8'hE7; req_a[0] = 2'b01;
      w = pick(0, 2'b01);
      do_frame(0, 2, 2, 2'b01, 8'h5A, 8'hE7, 6, 1'b0, "drop");
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (ss_a[0] !== 1'b1 || done_a[0] !== 2'b00) n++;
         @(negedge clk);
      end
      check("drop_no_restart", n, 0);

      // Reset during the 5th SCK high phase
      tx0_a[0] = 8'h96; s_data[0] = 8'h69; req_a[0] = 2'b01;
      rises = 0; psck = 1'b0; n = 0;
      while (rises < 5 && n < 200) begin
         @(negedge clk);
         n++;
         if (sck_a[0] === 1'b1 && psck === 1'b0) rises++;
         psck = sck_a[0];
      end
      check("abort_reach", rises, 5);
      rst = 1'b1; req_a[0] = 2'b00;
      @(negedge clk);
      check("abort_pins", {ss_a[0], sck_a[0]}, 2'b10);
      check("abort_ctl", {gnt_a[0], done_a[0]}, 4'b0000);
      check("abort_rx", rx_a[0], 8'h00);
      rst = 1'b0; favour[0] = 1'b0; favour[1] = 1'b0;
      @(negedge clk);
      check("abort_no_done", done_a[0], 2'b00);
      tx0_a[0] = 8'hC3; s_data[0] = 8'h81; req_a[0] = 2'b01;
      w = pick(0, 2'b01);
      do_frame(0, 2, 2, 2'b01, 8'hC3, 8'h81, -1, 1'b1, "after_abort");

      // Fastest divider and gap
      tx1_a[1] = 8'hFF; s_data[1] = 8'h00; req_a[1] = 2'b10;
      w = pick(1, 2'b10);
      do_frame(1, 1, 1, 2'b10, 8'hFF, 8'h00, -1, 1'b1, "div1");

      // Random request patterns and bytes against the reference
      for (int i = 0; i < 8; i++) begin
         r  = 2'($urandom_range(1, 3));
         t0 = 8'($urandom); t1 = 8'($urandom); sd = 8'($urandom);
         tx0_a[1] = t0; tx1_a[1] = t1; s_data[1] = sd; req_a[1] = r;
         w = pick(1, r);
         do_frame(1, 1, 1, w ? 2'b10 : 2'b01, w ? t1 : t0, sd, -1, 1'b1,
                  $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
